alu_sequencer: RTL

//  Owns the accumulator (AC) and extend bit (E), and sequences the shared ALU for register-reference commands.

---
 rtl/alu_seq_pkg.sv | 46 ++++
 rtl/alu_sequencer_alu.sv | 50 +++++
 rtl/alu_sequencer.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/alu_seq_pkg.sv
// ============================================================================
// Module : alu_seq_pkg
// Brief  : Shared types for the ALU sequencer: command opcodes, FSM states and
//          the one-hot ALU operation select.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package alu_seq_pkg;

  typedef enum logic [3:0] {
    CMD_NOP = 4'd0,
    CMD_AND = 4'd1,
    CMD_ADD = 4'd2,
    CMD_LDA = 4'd3,
    CMD_INP = 4'd4,
    CMD_CMA = 4'd5,
    CMD_CIR = 4'd6,
    CMD_CIL = 4'd7,
    CMD_CLA = 4'd8,
    CMD_CLE = 4'd9,
    CMD_CME = 4'd10,
    CMD_INC = 4'd11
  } cmd_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EXEC  = 2'd1,
    SHIFT = 2'd2
  } state_e;

  localparam int SHIFT_ZERO_MEANS = 16;

  typedef struct packed {
    logic op_and;
    logic op_add;
    logic op_lda;
    logic op_inp;
    logic op_cma;
    logic op_cir;
    logic op_cil;
  } alu_op_t;

endpackage

`default_nettype wire

// File: rtl/alu_sequencer_alu.sv
// ============================================================================
// Module : alu_sequencer_alu
// Brief  : Shared combinational ALU; one-hot op select, no op selected yields 0.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_sequencer_alu
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] i_ac,
  input  logic             i_e,
  input  logic [WIDTH-1:0] i_dr,
  input  logic [7:0]       i_inpr,
  input  alu_op_t          i_op,
  output logic [WIDTH-1:0] o_ac,
  output logic             o_e
);

  logic [WIDTH:0] w_sum;

  assign w_sum = {1'b0, i_ac} + {1'b0, i_dr};

  // Results are OR-combined; the select is one-hot so at most one term is live.
  always_comb begin
    o_ac = '0;
    o_e  = i_e;
    if (i_op.op_and) o_ac = o_ac | (i_ac & i_dr);
    if (i_op.op_add) begin
      o_ac = o_ac | w_sum[WIDTH-1:0];
      o_e  = w_sum[WIDTH];
    end
    if (i_op.op_lda) o_ac = o_ac | i_dr;
    if (i_op.op_inp) o_ac = o_ac | {{(WIDTH-8){1'b0}}, i_inpr};
    if (i_op.op_cma) o_ac = o_ac | ~i_ac;
    if (i_op.op_cir) begin
      o_ac = o_ac | {i_e, i_ac[WIDTH-1:1]};
      o_e  = i_ac[0];
    end
    if (i_op.op_cil) begin
      o_ac = o_ac | {i_ac[WIDTH-2:0], i_e};
      o_e  = i_ac[WIDTH-1];
    end
  end

endmodule

`default_nettype wire

// File: rtl/alu_sequencer.sv
// ============================================================================
// Module : alu_sequencer
// Brief  : Owns AC/E and sequences the shared ALU for register-reference
//          commands. Optional ALU_SEQ_FLAGS_EN adds AC/E status flag outputs.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int CNT_WIDTH = 4
) (
  input  logic                 clk_in,
  input  logic                 rst_n_in,
  input  logic                 cmd_valid_in,
  output logic                 cmd_ready_out,
  input  logic [3:0]           cmd_in,
  input  logic [WIDTH-1:0]     dr_in,
  input  logic [7:0]           inpr_in,
  input  logic [CNT_WIDTH-1:0] count_in,
  output logic                 done_out,
  output logic                 err_out,
  output logic [WIDTH-1:0]     ac_out,
  output logic                 e_out
`ifdef ALU_SEQ_FLAGS_EN
  ,
  output logic                 ac_zero_out,
  output logic                 ac_neg_out,
  output logic                 e_zero_out
`endif
);

  localparam int CNTW = CNT_WIDTH + 1;

  state_e           r_state;
  state_e           w_state_nxt;
  logic [3:0]       r_cmd;
  logic [WIDTH-1:0] r_dr;
  logic [7:0]       r_inpr;
  logic [CNTW-1:0]  r_cnt;
  logic [WIDTH-1:0] r_ac;
  logic             r_e;
  logic             r_done;
  logic             r_err;

  logic             w_ready;
  logic             w_accept;
  logic [WIDTH-1:0] w_ac_nxt;
  logic             w_e_nxt;
  logic             w_done_nxt;
  logic             w_err_nxt;
  alu_op_t          w_op;
  logic [WIDTH-1:0] w_alu_dr;
  logic [WIDTH-1:0] w_alu_ac;
  logic             w_alu_e;

  alu_sequencer_alu #(
    .WIDTH (WIDTH)
  ) u_alu (
    .i_ac   (r_ac),
    .i_e    (r_e),
    .i_dr   (w_alu_dr),
    .i_inpr (r_inpr),
    .i_op   (w_op),
    .o_ac   (w_alu_ac),
    .o_e    (w_alu_e)
  );

  // Op decode depends only on registered state so the ALU path stays acyclic.
  always_comb begin
    w_op     = '0;
    w_alu_dr = r_dr;
    if (r_state == SHIFT) begin
      w_op.op_cir = (r_cmd == CMD_CIR);
      w_op.op_cil = (r_cmd != CMD_CIR);
    end else if (r_state == EXEC) begin
      case (r_cmd)
        CMD_AND: w_op.op_and = 1'b1;
        CMD_ADD: w_op.op_add = 1'b1;
        CMD_LDA: w_op.op_lda = 1'b1;
        CMD_INP: w_op.op_inp = 1'b1;
        CMD_CMA: w_op.op_cma = 1'b1;
        CMD_INC: begin
          w_op.op_add = 1'b1;
          w_alu_dr    = WIDTH'(1);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ready     = 1'b0;
    w_accept    = 1'b0;
    w_ac_nxt    = r_ac;
    w_e_nxt     = r_e;
    w_done_nxt  = 1'b0;
    w_err_nxt   = 1'b0;
    case (r_state)
      IDLE: begin
        w_ready = 1'b1;
        if (cmd_valid_in) begin
          w_accept    = 1'b1;
          w_state_nxt = ((cmd_in == CMD_CIR) || (cmd_in == CMD_CIL)) ? SHIFT : EXEC;
        end
      end
      EXEC: begin
        w_state_nxt = IDLE;
        w_done_nxt  = 1'b1;
        case (r_cmd)
          CMD_AND, CMD_LDA, CMD_INP, CMD_CMA, CMD_CLA, CMD_INC: w_ac_nxt = w_alu_ac;
          CMD_ADD: begin
            w_ac_nxt = w_alu_ac;
            w_e_nxt  = w_alu_e;
          end
          CMD_CLE: w_e_nxt = 1'b0;
          CMD_CME: w_e_nxt = ~r_e;
          CMD_NOP, CMD_CIR, CMD_CIL: ;
          default: w_err_nxt = 1'b1;
        endcase
      end
      SHIFT: begin
        w_ac_nxt = w_alu_ac;
        w_e_nxt  = w_alu_e;
        if (r_cnt == CNTW'(1)) begin
          w_state_nxt = IDLE;
          w_done_nxt  = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      r_state <= IDLE;
      r_cmd   <= CMD_NOP;
      r_dr    <= '0;
      r_inpr  <= '0;
      r_cnt   <= '0;
      r_ac    <= '0;
      r_e     <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ac    <= w_ac_nxt;
      r_e     <= w_e_nxt;
      r_done  <= w_done_nxt;
      r_err   <= w_err_nxt;
      if (w_accept) begin
        r_cmd  <= cmd_in;
        r_dr   <= dr_in;
        r_inpr <= inpr_in;
        // A zero count encodes a full-width rotate.
        r_cnt  <= (count_in == '0) ? CNTW'(SHIFT_ZERO_MEANS) : {1'b0, count_in};
      end else if (r_state == SHIFT) begin
        r_cnt  <= r_cnt - CNTW'(1);
      end
    end
  end

  assign cmd_ready_out = w_ready;
  assign done_out      = r_done;
  assign err_out       = r_err;
  assign ac_out        = r_ac;
  assign e_out         = r_e;

`ifdef ALU_SEQ_FLAGS_EN
  assign ac_zero_out = (r_ac == '0);
  assign ac_neg_out  = r_ac[WIDTH-1];
  assign e_zero_out  = ~r_e;
`endif

endmodule

`default_nettype wire
